// File: rtl/bp_be_issue_buffer.sv
// In-order issue buffer between the FE fetch queue and the BE issue stage: stamps itags and owns FE redirects.
// Optional zero-latency fetch bypass into an empty buffer is enabled with BP_BE_ISSUE_BYPASS_EN.
module bp_be_issue_buffer #(
  parameter int els_p         = 8,
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int itag_width_p  = 8,
  parameter logic [vaddr_width_p-1:0] pc_entry_p = 39'h80000108
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     fe_v_i,
  input  logic [vaddr_width_p-1:0] fe_pc_i,
  input  logic [instr_width_p-1:0] fe_instr_i,
  output logic                     fe_ready_o,
  output logic                     issue_v_o,
  output logic [vaddr_width_p-1:0] issue_pc_o,
  output logic [instr_width_p-1:0] issue_instr_o,
  output logic [itag_width_p-1:0]  issue_itag_o,
  input  logic                     issue_yumi_i,
  input  logic                     flush_i,
  input  logic [vaddr_width_p-1:0] flush_pc_i,
  output logic                     redirect_v_o,
  output logic [vaddr_width_p-1:0] redirect_pc_o,
  input  logic                     redirect_ready_i
);

  localparam int ptr_w = $clog2(els_p);

  typedef enum logic {e_redirect, e_run} state_e;

  typedef struct packed {
    logic [vaddr_width_p-1:0] pc;
    logic [instr_width_p-1:0] instr;
    logic [itag_width_p-1:0]  itag;
  } entry_s;

  state_e                   state;
  logic [vaddr_width_p-1:0] redirect_pc;
  logic [itag_width_p-1:0]  itag_cnt;
  logic [ptr_w:0]           rd_ptr, wr_ptr;
  entry_s                   mem [els_p];
  entry_s                   hold_q, head, issue_ent;

  logic run, empty, full, fe_acc, enq, deq, byp_v, byp_take;

  assign run   = (state == e_run);
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[ptr_w-1:0] == wr_ptr[ptr_w-1:0]) && (rd_ptr[ptr_w] != wr_ptr[ptr_w]);

`ifdef BP_BE_ISSUE_BYPASS_EN
  assign byp_v    = run & empty & fe_v_i;
  assign byp_take = byp_v & issue_yumi_i & ~flush_i;
`else
  assign byp_v    = 1'b0;
  assign byp_take = 1'b0;
`endif

  // During redirect every fetch is accepted so wrong-path packets drain out of the FE
  assign fe_ready_o = run ? ~full : 1'b1;
  assign fe_acc     = run & fe_v_i & ~full & ~flush_i;
  assign enq        = fe_acc & ~byp_take;
  assign deq        = run & issue_yumi_i & ~empty & ~flush_i;

  // Head fields keep showing the last buffered head once the buffer drains
  assign head      = empty ? hold_q : mem[rd_ptr[ptr_w-1:0]];
  assign issue_ent = byp_v ? '{pc: fe_pc_i, instr: fe_instr_i, itag: itag_cnt} : head;

  assign issue_v_o     = run & (~empty | byp_v);
  assign issue_pc_o    = issue_ent.pc;
  assign issue_instr_o = issue_ent.instr;
  assign issue_itag_o  = issue_ent.itag;
  assign redirect_v_o  = ~run;
  assign redirect_pc_o = redirect_pc;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= e_redirect;
      redirect_pc <= pc_entry_p;
      itag_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      hold_q      <= '0;
    end else begin
      hold_q <= head;
      if (flush_i) begin
        state       <= e_redirect;
        redirect_pc <= flush_pc_i;
        rd_ptr      <= wr_ptr;
      end else begin
        if (!run && redirect_ready_i) state <= e_run;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        if (enq) wr_ptr <= wr_ptr + 1'b1;
      end
      if (fe_acc) itag_cnt <= itag_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr[ptr_w-1:0]] <= '{pc: fe_pc_i, instr: fe_instr_i, itag: itag_cnt};
  end

endmodule

// File: tb/tb_bp_be_issue_buffer.sv
// Directed bench for bp_be_issue_buffer: queue-based model checked every negedge plus literal spot checks.
module tb_bp_be_issue_buffer;
  localparam int ELS = 8;
  localparam logic [38:0] ENTRY = 39'h80000108;

  logic clk = 0, rst_n = 0;
  logic fe_v = 0, yumi = 0, flush = 0, rready = 0;
  logic [38:0] fe_pc = '0, flush_pc = '0;
  logic [31:0] fe_instr = '0;
  logic fe_ready, issue_v, redirect_v;
  logic [38:0] issue_pc, redirect_pc;
  logic [31:0] issue_instr;
  logic [7:0] issue_itag;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  bp_be_issue_buffer dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .fe_v_i(fe_v), .fe_pc_i(fe_pc), .fe_instr_i(fe_instr), .fe_ready_o(fe_ready),
    .issue_v_o(issue_v), .issue_pc_o(issue_pc), .issue_instr_o(issue_instr), .issue_itag_o(issue_itag),
    .issue_yumi_i(yumi), .flush_i(flush), .flush_pc_i(flush_pc),
    .redirect_v_o(redirect_v), .redirect_pc_o(redirect_pc), .redirect_ready_i(rready)
  );

  typedef struct {logic [38:0] pc; logic [31:0] instr; logic [7:0] itag;} ent_t;
  ent_t q[$];
  bit          m_run;
  logic [38:0] m_rpc;
  logic [7:0]  m_itag;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a FIFO of stamped packets, a run/redirect flag, a target and a tag counter
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_run = 0; m_rpc = ENTRY; m_itag = 0;
    end else if (flush) begin
      if (m_run && fe_v && q.size() < ELS) begin end
      q.delete(); m_run = 0; m_rpc = flush_pc;
    end else if (!m_run) begin
      if (rready) m_run = 1;
    end else begin
      bit was_empty, acc, take;
      was_empty = (q.size() == 0);
      acc = fe_v && (q.size() < ELS);
`ifdef BP_BE_ISSUE_BYPASS_EN
      take = was_empty && fe_v && yumi;
`else
      take = 0;
`endif
      if (yumi && !was_empty) void'(q.pop_front());
      if (acc) begin
        if (!take) q.push_back('{fe_pc, fe_instr, m_itag});
        m_itag = m_itag + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ent_t e;
    ev = m_run && q.size() > 0;
    if (q.size() > 0) e = q[0];
`ifdef BP_BE_ISSUE_BYPASS_EN
    if (m_run && q.size() == 0 && fe_v) begin ev = 1; e = '{fe_pc, fe_instr, m_itag}; end
`endif
    chk("redirect_v", redirect_v, !m_run);
    chk("fe_ready", fe_ready, m_run ? (q.size() < ELS) : 1'b1);
    chk("issue_v", issue_v, ev);
    if (!m_run) chk("redirect_pc", redirect_pc, m_rpc);
    if (ev) begin
      chk("issue_pc", issue_pc, e.pc);
      chk("issue_instr", issue_instr, e.instr);
      chk("issue_itag", issue_itag, e.itag);
    end
    if (!rst_n) chk("reset_fields", {issue_pc, issue_itag}, '0);
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic fetch(logic v, logic [38:0] pc, logic y);
    fe_v = v; fe_pc = pc; fe_instr = {pc[29:0], 2'b11}; yumi = y;
  endtask
  task automatic accept_redirect; rready = 1; tick; rready = 0; endtask

  initial begin
    repeat (2) tick;
    chk("rst_issue_v", issue_v, 0);
    chk("rst_fe_ready", fe_ready, 1);
    chk("rst_redirect_pc", redirect_pc, ENTRY);
    rst_n = 1;

    // Wrong-path fetches offered while the redirect is pending must vanish
    for (int i = 0; i < 3; i++) begin
      fetch(1, 39'h7000 + 39'(i*4), 0);
      tick;
      chk("redir_hold_v", redirect_v, 1);
      chk("redir_hold_pc", redirect_pc, ENTRY);
    end
    fetch(0, 0, 0);
    accept_redirect;
    chk("drop_issue_v", issue_v, 0);

    // Fill to full
    for (int k = 0; k < 8; k++) begin fetch(1, ENTRY + 39'(4*k), 0); tick; end
    fetch(0, 0, 0);
    chk("full_fe_ready", fe_ready, 0);
    chk("first_itag", issue_itag, 0);
    chk("first_pc", issue_pc, ENTRY);
    yumi = 1; tick;
    chk("ready_after_yumi", fe_ready, 1);
    repeat (7) tick;
    yumi = 0;
    chk("drained_v", issue_v, 0);

    // Steady stream with occupancy one; tags wrap through 255
    fetch(1, 39'h10000, 0); tick;
    for (int i = 0; i < 300; i++) begin fetch(1, 39'h10004 + 39'(4*i), 1); tick; end
    fetch(0, 0, 1); tick;
    fetch(0, 0, 0);

    // Flush with three entries and a coincident yumi
    for (int k = 0; k < 3; k++) begin fetch(1, 39'h20000 + 39'(4*k), 0); tick; end
    fetch(0, 0, 1); flush = 1; flush_pc = 39'h80001000; tick;
    flush = 0; yumi = 0;
    chk("flush_issue_v", issue_v, 0);
    chk("flush_redirect_pc", redirect_pc, 39'h80001000);

    // Flush racing a redirect acceptance keeps the redirect alive with the newer target
    flush = 1; flush_pc = 39'h80002000; rready = 1; tick;
    flush = 0; rready = 0;
    chk("reflush_v", redirect_v, 1);
    chk("reflush_pc", redirect_pc, 39'h80002000);
    accept_redirect;
    fetch(1, 39'h80002000, 0); tick; fetch(0, 0, 0);
    chk("post_flush_itag", issue_itag, 8'd56);

    // Asynchronous reset landing mid-cycle
    fetch(1, 39'h30000, 0); tick; tick;
    #2 rst_n = 0; #1;
    chk("async_issue_v", issue_v, 0);
    chk("async_redirect", {redirect_v, redirect_pc}, {1'b1, ENTRY});
    chk("async_fe_ready", fe_ready, 1);
    chk("async_itag", issue_itag, 0);
    fetch(0, 0, 0);
    tick; rst_n = 1;
    accept_redirect;
    fetch(1, 39'h40000, 0); tick; fetch(0, 0, 0);
    chk("reset_itag", issue_itag, 0);
    yumi = 1; tick; yumi = 0;

`ifdef BP_BE_ISSUE_BYPASS_EN
    fetch(1, 39'h50000, 1); #1;
    chk("byp_same_cycle_v", issue_v, 1);
    chk("byp_pc", issue_pc, 39'h50000);
    tick; fetch(0, 0, 0); #1;
    chk("byp_empty_after", issue_v, 0);
`endif
    tick; tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
